// File: rtl/exu_lsu_pkg.sv
// Shared types and constants for the execute-stage load/store unit.
// The optional ERR state exists only when EXU_LSU_MISALIGN_CHK_EN is defined.
package exu_lsu_pkg;

    localparam int unsigned RV_XLEN      = 32;
    localparam int unsigned RV_GPR_AW    = 5;
    localparam int unsigned LSU_OPC_SIZE = 4;

    // Encoding: [3] = store, [2] = unsigned load, [1:0] = access size.
    typedef enum logic [LSU_OPC_SIZE-1:0] {
        LsuLb  = 4'h0,
        LsuLh  = 4'h1,
        LsuLw  = 4'h2,
        LsuLbu = 4'h4,
        LsuLhu = 4'h5,
        LsuSb  = 4'h8,
        LsuSh  = 4'h9,
        LsuSw  = 4'hA
    } lsu_opc_e;

    // Bit index of the store flag inside an opcode.
    localparam int unsigned LSU_OPC_IS_STORE = 3;

    localparam logic [1:0] LSU_SIZE_B = 2'd0;
    localparam logic [1:0] LSU_SIZE_H = 2'd1;
    localparam logic [1:0] LSU_SIZE_W = 2'd2;

    typedef enum logic [2:0] {
        StIdle,
        StReq,
        StRsp,
        StDone
`ifdef EXU_LSU_MISALIGN_CHK_EN
        , StErr
`endif
    } lsu_state_e;

    // True only for the eight defined opcodes; everything else is a no-op.
    function automatic logic lsu_opc_known(input logic [LSU_OPC_SIZE-1:0] opc);
        case (opc)
            LsuLb, LsuLh, LsuLw, LsuLbu, LsuLhu, LsuSb, LsuSh, LsuSw: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/exu_lsu_align.sv
// Combinational lane logic: store strobes/data replication and load extraction/extension.
module exu_lsu_align
    import exu_lsu_pkg::*;
(
    input  logic [LSU_OPC_SIZE-1:0] st_opc,
    input  logic [1:0]              st_ofs,
    input  logic [31:0]             st_wdata,
    input  logic [LSU_OPC_SIZE-1:0] ld_opc,
    input  logic [1:0]              ld_ofs,
    input  logic [31:0]             ld_rdata,
    output logic [3:0]              st_wstrb,
    output logic [31:0]             st_wdata_rep,
    output logic [31:0]             ld_data
);

    logic [31:0] byte_sh;
    logic [31:0] half_sh;

    // Halfword lanes use only addr[1]; a misaligned halfword is silently aligned down.
    always_comb begin
        byte_sh = ld_rdata >> {ld_ofs, 3'b000};
        half_sh = ld_rdata >> {ld_ofs[1], 4'b0000};
    end

    // Store side: byte enables and lane-replicated write data; zero for non-stores.
    always_comb begin
        st_wstrb     = 4'b0000;
        st_wdata_rep = '0;
        case (st_opc)
            LsuSb: begin
                st_wstrb     = 4'b0001 << st_ofs;
                st_wdata_rep = {4{st_wdata[7:0]}};
            end
            LsuSh: begin
                st_wstrb     = 4'b0011 << {st_ofs[1], 1'b0};
                st_wdata_rep = {2{st_wdata[15:0]}};
            end
            LsuSw: begin
                st_wstrb     = 4'b1111;
                st_wdata_rep = st_wdata;
            end
            default: ;
        endcase
    end

    // Load side: pick the addressed lane and sign- or zero-extend it.
    always_comb begin
        ld_data = '0;
        case (ld_opc)
            LsuLb:  ld_data = {{24{byte_sh[7]}}, byte_sh[7:0]};
            LsuLbu: ld_data = {24'h0, byte_sh[7:0]};
            LsuLh:  ld_data = {{16{half_sh[15]}}, half_sh[15:0]};
            LsuLhu: ld_data = {16'h0, half_sh[15:0]};
            LsuLw:  ld_data = ld_rdata;
            default: ;
        endcase
    end

endmodule

// File: rtl/exu_lsu.sv
// Execute-stage load/store unit: one valid/ready memory transaction in flight at a time.
// Optional misaligned-access trap enabled by defining EXU_LSU_MISALIGN_CHK_EN.
module exu_lsu
    import exu_lsu_pkg::*;
#(
    parameter int unsigned XLEN   = RV_XLEN,
    parameter int unsigned GPR_AW = RV_GPR_AW
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    req_vld,
    output logic                    req_rdy,
    input  logic [LSU_OPC_SIZE-1:0] req_opc,
    input  logic [XLEN-1:0]         req_addr,
    input  logic [XLEN-1:0]         req_wdata,
    input  logic [GPR_AW-1:0]       req_rd,
    output logic                    mem_req_vld,
    input  logic                    mem_req_rdy,
    output logic [XLEN-1:0]         mem_req_addr,
    output logic                    mem_req_wen,
    output logic [XLEN-1:0]         mem_req_wdata,
    output logic [3:0]              mem_req_wstrb,
    input  logic                    mem_rsp_vld,
    output logic                    mem_rsp_rdy,
    input  logic [XLEN-1:0]         mem_rsp_rdata,
    output logic [GPR_AW-1:0]       gpr_waddr,
    output logic [XLEN-1:0]         gpr_wdata,
    output logic                    gpr_wen,
    output logic                    done
`ifdef EXU_LSU_MISALIGN_CHK_EN
    ,
    output logic                    misalign
`endif
);

    lsu_state_e              state_q, state_d;
    logic [LSU_OPC_SIZE-1:0] opc_q, opc_d;
    logic [1:0]              ofs_q, ofs_d;
    logic [GPR_AW-1:0]       rd_q, rd_d;
    logic [XLEN-1:0]         addr_q, addr_d;
    logic                    wen_q, wen_d;
    logic [XLEN-1:0]         wdata_q, wdata_d;
    logic [3:0]              wstrb_q, wstrb_d;
    logic [XLEN-1:0]         ldata_q, ldata_d;

    logic [3:0]              st_wstrb;
    logic [XLEN-1:0]         st_wdata_rep;
    logic [XLEN-1:0]         ld_data;
    logic                    req_known;

    assign req_known = lsu_opc_known(req_opc);

    // Store lanes come from the incoming request; load lanes from the latched op.
    exu_lsu_align u_align (
        .st_opc       (req_opc),
        .st_ofs       (req_addr[1:0]),
        .st_wdata     (req_wdata),
        .ld_opc       (opc_q),
        .ld_ofs       (ofs_q),
        .ld_rdata     (mem_rsp_rdata),
        .st_wstrb     (st_wstrb),
        .st_wdata_rep (st_wdata_rep),
        .ld_data      (ld_data)
    );

    // Next-state and operand capture; bus fields are frozen from accept until the next op.
    always_comb begin
        state_d = state_q;
        opc_d   = opc_q;
        ofs_d   = ofs_q;
        rd_d    = rd_q;
        addr_d  = addr_q;
        wen_d   = wen_q;
        wdata_d = wdata_q;
        wstrb_d = wstrb_q;
        ldata_d = ldata_q;
        case (state_q)
            StIdle: begin
                if (req_vld) begin
                    opc_d   = req_opc;
                    ofs_d   = req_addr[1:0];
                    rd_d    = req_rd;
                    addr_d  = {req_addr[XLEN-1:2], 2'b00};
                    wen_d   = req_known & req_opc[LSU_OPC_IS_STORE];
                    wdata_d = st_wdata_rep;
                    wstrb_d = st_wstrb;
                    if (!req_known) begin
                        state_d = StDone;
`ifdef EXU_LSU_MISALIGN_CHK_EN
                    end else if ((req_opc[1:0] == LSU_SIZE_H && req_addr[0]) ||
                                 (req_opc[1:0] == LSU_SIZE_W && req_addr[1:0] != 2'b00)) begin
                        state_d = StErr;
`endif
                    end else begin
                        state_d = StReq;
                    end
                end
            end
            StReq: begin
                if (mem_req_rdy) state_d = StRsp;
            end
            StRsp: begin
                if (mem_rsp_vld) begin
                    ldata_d = ld_data;
                    state_d = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and operand registers; reset drops any outstanding op.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            opc_q   <= '0;
            ofs_q   <= '0;
            rd_q    <= '0;
            addr_q  <= '0;
            wen_q   <= 1'b0;
            wdata_q <= '0;
            wstrb_q <= '0;
            ldata_q <= '0;
        end else begin
            state_q <= state_d;
            opc_q   <= opc_d;
            ofs_q   <= ofs_d;
            rd_q    <= rd_d;
            addr_q  <= addr_d;
            wen_q   <= wen_d;
            wdata_q <= wdata_d;
            wstrb_q <= wstrb_d;
            ldata_q <= ldata_d;
        end
    end

    // Outputs decoded from the registered state; pulses last exactly one cycle.
    always_comb begin
        req_rdy       = (state_q == StIdle);
        mem_req_vld   = (state_q == StReq);
        mem_rsp_rdy   = (state_q == StRsp);
        mem_req_addr  = addr_q;
        mem_req_wen   = wen_q;
        mem_req_wdata = wdata_q;
        mem_req_wstrb = wstrb_q;
        gpr_waddr     = rd_q;
        gpr_wdata     = ldata_q;
        gpr_wen       = (state_q == StDone) && lsu_opc_known(opc_q) &&
                        !opc_q[LSU_OPC_IS_STORE] && (rd_q != '0);
        done          = (state_q == StDone);
`ifdef EXU_LSU_MISALIGN_CHK_EN
        misalign      = (state_q == StErr);
        done          = (state_q == StDone) || (state_q == StErr);
`endif
    end

endmodule

// File: tb/tb_exu_lsu.sv
// Self-checking bench for exu_lsu: table of zero-wait ops plus stall, reset and corner sequences.
module tb_exu_lsu;
    import exu_lsu_pkg::*;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        req_vld = 1'b0;
    logic        req_rdy;
    logic [3:0]  req_opc = '0;
    logic [31:0] req_addr = '0;
    logic [31:0] req_wdata = '0;
    logic [4:0]  req_rd = '0;
    logic        mem_req_vld;
    logic        mem_req_rdy = 1'b0;
    logic [31:0] mem_req_addr;
    logic        mem_req_wen;
    logic [31:0] mem_req_wdata;
    logic [3:0]  mem_req_wstrb;
    logic        mem_rsp_vld = 1'b0;
    logic        mem_rsp_rdy;
    logic [31:0] mem_rsp_rdata = '0;
    logic [4:0]  gpr_waddr;
    logic [31:0] gpr_wdata;
    logic        gpr_wen;
    logic        done;
`ifdef EXU_LSU_MISALIGN_CHK_EN
    logic        misalign;
`endif

    int passed = 0;
    int total  = 0;

    exu_lsu dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .req_vld       (req_vld),
        .req_rdy       (req_rdy),
        .req_opc       (req_opc),
        .req_addr      (req_addr),
        .req_wdata     (req_wdata),
        .req_rd        (req_rd),
        .mem_req_vld   (mem_req_vld),
        .mem_req_rdy   (mem_req_rdy),
        .mem_req_addr  (mem_req_addr),
        .mem_req_wen   (mem_req_wen),
        .mem_req_wdata (mem_req_wdata),
        .mem_req_wstrb (mem_req_wstrb),
        .mem_rsp_vld   (mem_rsp_vld),
        .mem_rsp_rdy   (mem_rsp_rdy),
        .mem_rsp_rdata (mem_rsp_rdata),
        .gpr_waddr     (gpr_waddr),
        .gpr_wdata     (gpr_wdata),
        .gpr_wen       (gpr_wen),
        .done          (done)
`ifdef EXU_LSU_MISALIGN_CHK_EN
        ,
        .misalign      (misalign)
`endif
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct {
        string       name;
        logic [3:0]  opc;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [4:0]  rd;
        logic [31:0] rsp;
        logic [31:0] exp_addr;
        logic        exp_wen;
        logic [3:0]  exp_wstrb;
        logic [31:0] exp_wdata;
        logic        exp_gwen;
        logic [31:0] exp_gdata;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) $display("FAIL %s: got %h, want %h", name, act, exp);
        else passed++;
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    // One op with a zero-wait bus; called at a negedge while the LSU is idle.
    task automatic run_vec(input vec_t v);
        chk({v.name, " req_rdy idle"}, 32'(req_rdy), 32'd1);
        req_vld = 1'b1; req_opc = v.opc; req_addr = v.addr;
        req_wdata = v.wdata; req_rd = v.rd;
        mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0;
        cyc();
        req_vld = 1'b0;
        chk({v.name, " mem_req_vld"}, 32'(mem_req_vld), 32'd1);
        chk({v.name, " mem_req_addr"}, mem_req_addr, v.exp_addr);
        chk({v.name, " mem_req_wen"}, 32'(mem_req_wen), 32'(v.exp_wen));
        chk({v.name, " mem_req_wstrb"}, 32'(mem_req_wstrb), 32'(v.exp_wstrb));
        if (v.exp_wen) chk({v.name, " mem_req_wdata"}, mem_req_wdata, v.exp_wdata);
        cyc();
        chk({v.name, " mem_rsp_rdy"}, 32'(mem_rsp_rdy), 32'd1);
        chk({v.name, " mem_req_vld drop"}, 32'(mem_req_vld), 32'd0);
        mem_rsp_vld = 1'b1; mem_rsp_rdata = v.rsp;
        cyc();
        mem_rsp_vld = 1'b0;
        chk({v.name, " done"}, 32'(done), 32'd1);
        chk({v.name, " gpr_wen"}, 32'(gpr_wen), 32'(v.exp_gwen));
        if (v.exp_gwen) begin
            chk({v.name, " gpr_waddr"}, 32'(gpr_waddr), 32'(v.rd));
            chk({v.name, " gpr_wdata"}, gpr_wdata, v.exp_gdata);
        end
        cyc();
        chk({v.name, " done pulse"}, 32'(done), 32'd0);
        chk({v.name, " gpr_wen pulse"}, 32'(gpr_wen), 32'd0);
        chk({v.name, " req_rdy back"}, 32'(req_rdy), 32'd1);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, " mem_req_vld"}, 32'(mem_req_vld), 32'd0);
        chk({tag, " mem_rsp_rdy"}, 32'(mem_rsp_rdy), 32'd0);
        chk({tag, " gpr_wen"}, 32'(gpr_wen), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " gpr_waddr"}, 32'(gpr_waddr), 32'd0);
        chk({tag, " gpr_wdata"}, gpr_wdata, 32'd0);
        chk({tag, " mem_req_addr"}, mem_req_addr, 32'd0);
        chk({tag, " mem_req_wdata"}, mem_req_wdata, 32'd0);
        chk({tag, " mem_req_wstrb"}, 32'(mem_req_wstrb), 32'd0);
        chk({tag, " mem_req_wen"}, 32'(mem_req_wen), 32'd0);
`ifdef EXU_LSU_MISALIGN_CHK_EN
        chk({tag, " misalign"}, 32'(misalign), 32'd0);
`endif
    endtask

    initial begin
        vec_t vecs[$];
        vec_t lw_dead;
        logic [31:0] held_addr;

        lw_dead = '{"lw", 4'h2, 32'h100, 32'h0, 5'd5, 32'hDEADBEEF,
                    32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hDEADBEEF};
        vecs.push_back(lw_dead);
        vecs.push_back('{"lb", 4'h0, 32'h103, 32'h0, 5'd6, 32'h80123456,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFF80});
        vecs.push_back('{"lbu", 4'h4, 32'h103, 32'h0, 5'd6, 32'h80123456,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h00000080});
        vecs.push_back('{"lh", 4'h1, 32'h102, 32'h0, 5'd7, 32'h80011234,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF8001});
        vecs.push_back('{"lhu", 4'h5, 32'h100, 32'h0, 5'd8, 32'h1234F00D,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'h0000F00D});
        vecs.push_back('{"lb1", 4'h0, 32'h101, 32'h0, 5'd9, 32'h1122A344,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFFFFA3});
        vecs.push_back('{"sb", 4'h8, 32'h201, 32'h12345678, 5'd3, 32'h0,
                         32'h200, 1'b1, 4'b0010, 32'h78787878, 1'b0, 32'h0});
        vecs.push_back('{"sh", 4'h9, 32'h302, 32'hCAFEBABE, 5'd3, 32'h0,
                         32'h300, 1'b1, 4'b1100, 32'hBABEBABE, 1'b0, 32'h0});
        vecs.push_back('{"sw", 4'hA, 32'h404, 32'h01020304, 5'd3, 32'h0,
                         32'h404, 1'b1, 4'b1111, 32'h01020304, 1'b0, 32'h0});
        vecs.push_back('{"lw_rd0", 4'h2, 32'h10, 32'h0, 5'd0, 32'h55,
                         32'h10, 1'b0, 4'b0000, 32'h0, 1'b0, 32'h0});
`ifndef EXU_LSU_MISALIGN_CHK_EN
        vecs.push_back('{"sw_mis", 4'hA, 32'h102, 32'hA0B0C0D0, 5'd1, 32'h0,
                         32'h100, 1'b1, 4'b1111, 32'hA0B0C0D0, 1'b0, 32'h0});
        vecs.push_back('{"lh_mis", 4'h1, 32'h103, 32'h0, 5'd2, 32'h80011234,
                         32'h100, 1'b0, 4'b0000, 32'h0, 1'b1, 32'hFFFF8001});
`endif

        // Reset state, asynchronously asserted before any clock edge.
        #1;
        chk_reset_outputs("por");
        chk("por req_rdy", 32'(req_rdy), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();

        foreach (vecs[i]) run_vec(vecs[i]);

        // Unknown opcode: straight to DONE, no bus request, no writeback.
        req_vld = 1'b1; req_opc = 4'h3; req_addr = 32'h40; req_rd = 5'd4;
        cyc();
        req_vld = 1'b0;
        chk("unk done", 32'(done), 32'd1);
        chk("unk mem_req_vld", 32'(mem_req_vld), 32'd0);
        chk("unk gpr_wen", 32'(gpr_wen), 32'd0);
        cyc();
        chk("unk req_rdy", 32'(req_rdy), 32'd1);
        chk("unk mem_req_vld after", 32'(mem_req_vld), 32'd0);

`ifdef EXU_LSU_MISALIGN_CHK_EN
        // Misaligned SW traps to ERR at N+1 with no bus traffic.
        req_vld = 1'b1; req_opc = 4'hA; req_addr = 32'h102; req_wdata = 32'h1; req_rd = 5'd1;
        cyc();
        req_vld = 1'b0;
        chk("mis misalign", 32'(misalign), 32'd1);
        chk("mis done", 32'(done), 32'd1);
        chk("mis mem_req_vld", 32'(mem_req_vld), 32'd0);
        chk("mis gpr_wen", 32'(gpr_wen), 32'd0);
        cyc();
        chk("mis req_rdy", 32'(req_rdy), 32'd1);
        chk("mis misalign pulse", 32'(misalign), 32'd0);
        chk("mis mem_req_vld after", 32'(mem_req_vld), 32'd0);
`endif

        // Stalled request for 5 cycles, then a 3-cycle response delay.
        req_vld = 1'b1; req_opc = 4'h2; req_addr = 32'h24; req_rd = 5'd4;
        mem_req_rdy = 1'b0;
        cyc();
        req_vld = 1'b0;
        mem_rsp_vld = 1'b1; mem_rsp_rdata = 32'hBAD0BAD0;
        held_addr = 32'h24;
        for (int i = 0; i < 5; i++) begin
            chk("stall mem_req_vld", 32'(mem_req_vld), 32'd1);
            chk("stall mem_req_addr", mem_req_addr, held_addr);
            chk("stall wstrb", 32'(mem_req_wstrb), 32'd0);
            chk("stall req_rdy", 32'(req_rdy), 32'd0);
            chk("stall mem_rsp_rdy", 32'(mem_rsp_rdy), 32'd0);
            cyc();
        end
        mem_req_rdy = 1'b1; mem_rsp_vld = 1'b0;
        chk("stall last mem_req_vld", 32'(mem_req_vld), 32'd1);
        cyc();
        mem_req_rdy = 1'b0;
        for (int i = 0; i < 3; i++) begin
            chk("rspwait mem_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
            chk("rspwait req_rdy", 32'(req_rdy), 32'd0);
            chk("rspwait done", 32'(done), 32'd0);
            chk("rspwait mem_req_vld", 32'(mem_req_vld), 32'd0);
            cyc();
        end
        mem_rsp_vld = 1'b1; mem_rsp_rdata = 32'h0000A5A5;
        cyc();
        mem_rsp_vld = 1'b0;
        chk("stall done", 32'(done), 32'd1);
        chk("stall gpr_wen", 32'(gpr_wen), 32'd1);
        chk("stall gpr_waddr", 32'(gpr_waddr), 32'd4);
        chk("stall gpr_wdata", gpr_wdata, 32'h0000A5A5);
        chk("stall req_rdy in done", 32'(req_rdy), 32'd0);
        cyc();
        chk("stall req_rdy back", 32'(req_rdy), 32'd1);

        // Reset asserted mid-transaction while in RSP.
        req_vld = 1'b1; req_opc = 4'hA; req_addr = 32'h88; req_wdata = 32'h11223344;
        req_rd = 5'd9; mem_req_rdy = 1'b1;
        cyc();
        req_vld = 1'b0;
        cyc();
        chk("rst pre mem_rsp_rdy", 32'(mem_rsp_rdy), 32'd1);
        #2 rst_n = 1'b0;
        #1;
        chk_reset_outputs("midrst");
        chk("midrst req_rdy", 32'(req_rdy), 32'd1);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("postrst req_rdy", 32'(req_rdy), 32'd1);
        run_vec(lw_dead);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
